// File: rtl/decimator_pkg.sv
// Shared constants and helpers for the decimator_m down-sampler.
package decimator_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_INTEG  = 1'b1;

  // Accumulator must hold the sum of up to 2**fw-1 samples of wl bits.
  function automatic int acc_width(input int wl, input int fw);
    return wl + fw;
  endfunction

  function automatic int floor_log2(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/decim_frame_ctr.sv
// Frame counter: latches mode/factor/phase at frame start and tracks the sample index.
// With DECIM_AVG_EN defined it also latches the averaging shift for the frame.
module decim_frame_ctr
  import decimator_pkg::*;
#(
  parameter int factor_w = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                accept,
  input  logic                mode,
  input  logic [factor_w-1:0] factor,
  input  logic [factor_w-1:0] phase,
  output logic                frame_start,
  output logic                is_phase,
  output logic                is_last,
  output logic                cur_mode
`ifdef DECIM_AVG_EN
  ,
  output logic [factor_w-1:0] shift
`endif
);

  logic [factor_w-1:0] cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [factor_w-1:0] m_q, m_d;
  logic [factor_w-1:0] ph_q, ph_d;
  logic [factor_w-1:0] m_in, ph_in, eff_m, eff_ph;
  logic                at_start;
`ifdef DECIM_AVG_EN
  logic [factor_w-1:0] shift_q, shift_d;
`endif

  always_comb begin
    m_in  = (factor == '0) ? factor_w'(1) : factor;
    ph_in = (phase >= m_in) ? (m_in - factor_w'(1)) : phase;

    // At cnt==0 the incoming configuration already governs the current beat.
    at_start    = (cnt_q == '0);
    cur_mode    = at_start ? mode  : mode_q;
    eff_m       = at_start ? m_in  : m_q;
    eff_ph      = at_start ? ph_in : ph_q;
    frame_start = accept && at_start;
    is_phase    = (cnt_q == eff_ph);
    is_last     = (cnt_q == (eff_m - factor_w'(1)));

    cnt_d  = cnt_q;
    mode_d = mode_q;
    m_d    = m_q;
    ph_d   = ph_q;
    if (accept) begin
      cnt_d = is_last ? '0 : (cnt_q + factor_w'(1));
    end
    if (frame_start) begin
      mode_d = mode;
      m_d    = m_in;
      ph_d   = ph_in;
    end
`ifdef DECIM_AVG_EN
    shift   = at_start ? factor_w'(floor_log2(32'(m_in))) : shift_q;
    shift_d = frame_start ? shift : shift_q;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      mode_q  <= MODE_SELECT;
      m_q     <= factor_w'(1);
      ph_q    <= '0;
`ifdef DECIM_AVG_EN
      shift_q <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      m_q     <= m_d;
      ph_q    <= ph_d;
`ifdef DECIM_AVG_EN
      shift_q <= shift_d;
`endif
    end
  end

endmodule

// File: rtl/decimator_m.sv
// Down-sampler top: select-at-phase or integrate-and-dump, one result per frame.
// Optional feature macro DECIM_AVG_EN: integrate mode outputs the sum >> floor(log2(M)).
module decimator_m
  import decimator_pkg::*;
#(
  parameter  int word_length = 8,
  parameter  int factor_w    = 4,
  localparam int acc_w       = acc_width(word_length, factor_w)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   in_valid,
  input  logic                   hold,
  input  logic                   mode,
  input  logic [factor_w-1:0]    factor,
  input  logic [factor_w-1:0]    phase,
  output logic [acc_w-1:0]       data_out,
  output logic                   out_valid
);

  logic             accept;
  logic             frame_start, is_phase, is_last, cur_mode;
  logic [acc_w-1:0] acc_q, acc_d;
  logic [acc_w-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic [acc_w-1:0] sum;
`ifdef DECIM_AVG_EN
  logic [factor_w-1:0] shift;
`endif

  assign accept = in_valid && !hold;

  decim_frame_ctr #(
    .factor_w(factor_w)
  ) u_ctr (
    .clock      (clock),
    .reset      (reset),
    .accept     (accept),
    .mode       (mode),
    .factor     (factor),
    .phase      (phase),
    .frame_start(frame_start),
    .is_phase   (is_phase),
    .is_last    (is_last),
    .cur_mode   (cur_mode)
`ifdef DECIM_AVG_EN
    ,
    .shift      (shift)
`endif
  );

  always_comb begin
    // A new frame always integrates from zero, whatever mode preceded it.
    sum    = (frame_start ? '0 : acc_q) + acc_w'(data_in);
    acc_d  = acc_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    if (accept) begin
      if (cur_mode == MODE_INTEG) begin
        if (is_last) begin
`ifdef DECIM_AVG_EN
          dout_d = sum >> shift;
`else
          dout_d = sum;
`endif
          acc_d  = '0;
          vld_d  = 1'b1;
        end else begin
          acc_d  = sum;
        end
      end else if (is_phase) begin
        dout_d = acc_w'(data_in);
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_decimator_m.sv
// Self-checking bench for decimator_m: frame-level reference model plus directed literal checks.
module tb_decimator_m;

  localparam int WL = 8;
  localparam int FW = 4;
  localparam int AW = WL + FW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [WL-1:0] data_in = '0;
  logic          in_valid = 1'b0;
  logic          hold = 1'b0;
  logic          mode = 1'b0;
  logic [FW-1:0] factor = '0;
  logic [FW-1:0] phase = '0;
  logic [AW-1:0] data_out;
  logic          out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int got[$];

  decimator_m #(.word_length(WL), .factor_w(FW)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .in_valid (in_valid),
    .hold     (hold),
    .mode     (mode),
    .factor   (factor),
    .phase    (phase),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_q(input string name, input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
    got.delete();
  endtask

  // Reference model: frame position, frame config and running sum as plain integers.
  int m_pos, m_M, m_ph, m_mode, m_s, m_sum;
  logic exp_vld;
  int   exp_dout;

  always @(posedge clock or posedge reset) begin
    int M, ph, md, s, pos, sum;
    if (reset) begin
      m_pos <= 0; m_M <= 1; m_ph <= 0; m_mode <= 0; m_s <= 0; m_sum <= 0;
      exp_vld <= 1'b0; exp_dout <= 0;
    end else begin
      exp_vld <= 1'b0;
      if (in_valid && !hold) begin
        pos = m_pos; M = m_M; ph = m_ph; md = m_mode; s = m_s; sum = m_sum;
        if (pos == 0) begin
          M  = (factor == 0) ? 1 : int'(factor);
          ph = (int'(phase) >= M) ? M - 1 : int'(phase);
          md = int'(mode);
          s  = 0;
          while ((2 << s) <= M) s++;
          sum = 0;
        end
        if (md == 0) begin
          if (pos == ph) begin
            exp_vld  <= 1'b1;
            exp_dout <= int'(data_in);
          end
        end else begin
          sum += int'(data_in);
          if (pos == M - 1) begin
            exp_vld <= 1'b1;
`ifdef DECIM_AVG_EN
            exp_dout <= sum >> s;
`else
            exp_dout <= sum;
`endif
            sum = 0;
          end
        end
        pos = (pos + 1) % M;
        m_pos <= pos; m_M <= M; m_ph <= ph; m_mode <= md; m_s <= s; m_sum <= sum;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("out_valid", int'(out_valid), int'(exp_vld));
      check("data_out", int'(data_out), exp_dout);
    end
    if (!reset && out_valid) got.push_back(int'(data_out));
  end

  task automatic drive(input bit v, input int d, input bit h);
    in_valid = v;
    data_in  = WL'(d);
    hold     = h;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  initial begin
    int e[$];
    #1;
    check("reset_data_out", int'(data_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);
    got.delete();

    // Reset mid-frame with cnt=2, acc=30
    mode = 1'b1; factor = 4'd4; phase = 4'd0;
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 0);
    drive(1, 10, 0); drive(1, 20, 0);
    in_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_data_out", int'(data_out), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    got.delete();
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 0);
    idle(2);
`ifdef DECIM_AVG_EN
    e = '{2};
`else
    e = '{10};
`endif
    check_q("restart_frame", e);

    // Select M=4 ph=2 over samples 10..21
    mode = 1'b0; factor = 4'd4; phase = 4'd2;
    for (int i = 10; i <= 21; i++) drive(1, i, 0);
    idle(2);
    e = '{12, 16, 20};
    check_q("select_m4_ph2", e);

    // Integrate M=3 with full-scale samples
    mode = 1'b1; factor = 4'd3;
    drive(1, 255, 0); drive(1, 255, 0); drive(1, 255, 0);
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0);
    idle(2);
`ifdef DECIM_AVG_EN
    e = '{382, 3};
`else
    e = '{765, 6};
`endif
    check_q("integ_m3", e);

    // Integrate M=4 with 5 held cycles whose samples must be dropped
    factor = 4'd4;
    drive(1, 1, 0); drive(1, 2, 0);
    for (int i = 0; i < 5; i++) drive(1, 100 + i, 1);
    drive(1, 3, 0); drive(1, 4, 0);
    idle(2);
`ifdef DECIM_AVG_EN
    e = '{2};
`else
    e = '{10};
`endif
    check_q("integ_hold", e);

    // factor 4 -> 2 mid-frame
    factor = 4'd4;
    drive(1, 1, 0); drive(1, 2, 0);
    factor = 4'd2;
    drive(1, 3, 0); drive(1, 4, 0);
    drive(1, 5, 0); drive(1, 6, 0); drive(1, 7, 0); drive(1, 8, 0);
    idle(2);
`ifdef DECIM_AVG_EN
    e = '{2, 5, 7};
`else
    e = '{10, 11, 15};
`endif
    check_q("factor_change", e);

    // factor=0 behaves as M=1, then phase clamp with M=3
    mode = 1'b0; factor = 4'd0; phase = 4'd7;
    drive(1, 5, 0); drive(1, 6, 0); drive(1, 7, 0);
    factor = 4'd3;
    for (int i = 1; i <= 6; i++) drive(1, i, 0);
    idle(2);
    e = '{5, 6, 7, 3, 6};
    check_q("factor0_clamp", e);

    // Randomized traffic with occasional async resets
    for (int c = 0; c < 4000; c++) begin
      mode   = 1'($urandom_range(0, 1));
      factor = FW'($urandom_range(0, 15));
      phase  = FW'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rand_reset_data_out", int'(data_out), 0);
        check("rand_reset_out_valid", int'(out_valid), 0);
        @(negedge clock);
        reset = 1'b0;
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 255), $urandom_range(0, 4) == 0);
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
